// File: rtl/formatter_sched.sv
// Round-robin burst scheduler for an 8:1 formatter mux. A channel keeps the
// mux for up to MAX_BURST words before the grant rotates to the next eligible one.
module formatter_sched #(
  parameter int MAX_BURST = 4
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic [7:0] req_i,
  input  logic [7:0] mask_i,
  input  logic       hold_i,
  output logic [2:0] sel_o,
  output logic [7:0] ack_o,
  output logic       out_valid_o,
  output logic [2:0] out_src_o,
  output logic       busy_o
);

  localparam int BW = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;
  localparam logic [BW-1:0] BCNT_END = BW'(MAX_BURST - 1);

  typedef enum logic {IDLE, GRANT} state_t;

  state_t          state_q, state_d;
  logic [2:0]      sel_q, sel_d;
  logic [2:0]      last_q, last_d;
  logic [BW-1:0]   bcnt_q, bcnt_d;
  logic            ov_q, ov_d;
  logic [2:0]      src_q, src_d;
  logic            busy_q, busy_d;
  logic [7:0]      elig;
  logic            xfer;
  logic [2:0]      arb_from, arb_pick;

  // First eligible channel in order p+1 .. p+8; p itself is checked last,
  // so the current owner only re-wins when nobody else is waiting.
  function automatic logic [2:0] pick(input logic [2:0] p, input logic [7:0] e);
    logic [2:0] r, c;
    logic       found;
    r     = p;
    found = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      c = p + 3'(k);
      if (!found && e[c]) begin
        r     = c;
        found = 1'b1;
      end
    end
    return r;
  endfunction

  always_comb begin
    elig     = req_i & mask_i;
    xfer     = (state_q == GRANT) && elig[sel_q] && !hold_i && !rst_i;
    ack_o    = '0;
    if (xfer) ack_o[sel_q] = 1'b1;
    arb_from = (state_q == IDLE) ? last_q : sel_q;
    arb_pick = pick(arb_from, elig);

    state_d  = state_q;
    sel_d    = sel_q;
    last_d   = last_q;
    bcnt_d   = bcnt_q;
    ov_d     = xfer;
    src_d    = xfer ? sel_q : src_q;

    unique case (state_q)
      IDLE: begin
        if (|elig) begin
          state_d = GRANT;
          sel_d   = arb_pick;
          bcnt_d  = '0;
        end
      end
      GRANT: begin
        // Everything freezes under backpressure.
        if (!hold_i) begin
          if (elig[sel_q] && bcnt_q != BCNT_END) begin
            bcnt_d = bcnt_q + BW'(1);
          end else begin
            // Burst end or dropped request: rearbitrate on this same edge.
            last_d = sel_q;
            bcnt_d = '0;
            if (|elig) sel_d = arb_pick;
            else       state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d == GRANT);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      sel_q   <= 3'd0;
      last_q  <= 3'd7;
      bcnt_q  <= '0;
      ov_q    <= 1'b0;
      src_q   <= 3'd0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      last_q  <= last_d;
      bcnt_q  <= bcnt_d;
      ov_q    <= ov_d;
      src_q   <= src_d;
      busy_q  <= busy_d;
    end
  end

  assign sel_o       = sel_q;
  assign out_valid_o = ov_q;
  assign out_src_o   = src_q;
  assign busy_o      = busy_q;

endmodule

// File: tb/tb_formatter_sched.sv
// Directed bench for formatter_sched: inputs change 1ns after posedge,
// outputs are checked 1ns later, well before the next edge.
module tb_formatter_sched;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] req, mask;
  logic       hold;
  logic [2:0] sel;
  logic [7:0] ack;
  logic       out_valid;
  logic [2:0] out_src;
  logic       busy;

  int n_assert = 0;
  int n_fail   = 0;

  formatter_sched #(.MAX_BURST(4)) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .req_i       (req),
    .mask_i      (mask),
    .hold_i      (hold),
    .sel_o       (sel),
    .ack_o       (ack),
    .out_valid_o (out_valid),
    .out_src_o   (out_src),
    .busy_o      (busy)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1; req = '0; mask = '0; hold = 1'b0;
    step();
    rst = 1'b0;
  endtask

  initial begin
    logic [2:0] ch, prev;
    rst = 1'b1; req = '0; mask = '0; hold = 1'b0;
    step();
    step();
    #1;
    chk("rst_sel", 32'(sel), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_ov", 32'(out_valid), 0);
    chk("rst_src", 32'(out_src), 0);
    chk("rst_ack", 32'(ack), 0);

    // Full rotation: all channels requesting, bursts of 4, wraps back to 0.
    rst = 1'b0; req = 8'hFF; mask = 8'hFF; hold = 1'b0;
    #1;
    chk("rr_idle_ack", 32'(ack), 0);
    chk("rr_idle_busy", 32'(busy), 0);
    step();
    chk("rr_busy", 32'(busy), 1);
    prev = 3'd0;
    for (int k = 0; k < 36; k++) begin
      ch = 3'((k / 4) % 8);
      chk("rr_ack", 32'(ack), 32'(8'h01 << ch));
      chk("rr_sel", 32'(sel), 32'(ch));
      if (k == 0) begin
        chk("rr_ov_first", 32'(out_valid), 0);
      end else begin
        chk("rr_ov", 32'(out_valid), 1);
        chk("rr_src", 32'(out_src), 32'(prev));
      end
      prev = ch;
      step();
    end
    // Reset mid-burst on ch1 with requests still pending.
    rst = 1'b1;
    #1;
    chk("rr_rst_ack", 32'(ack), 0);
    step();
    chk("rr_rst_sel", 32'(sel), 0);
    chk("rr_rst_busy", 32'(busy), 0);
    chk("rr_rst_ov", 32'(out_valid), 0);

    // Two channels alternate 2,5,2,5.
    do_reset();
    req = 8'h24; mask = 8'hFF;
    #1;
    chk("alt_idle_ack", 32'(ack), 0);
    step();
    for (int b = 0; b < 4; b++) begin
      for (int w = 0; w < 4; w++) begin
        ch = (b % 2 == 1) ? 3'd5 : 3'd2;
        chk("alt_ack", 32'(ack), 32'(8'h01 << ch));
        step();
      end
    end

    // Hold mid-burst on ch3 after two words; request set changes under hold.
    do_reset();
    req = 8'h08; mask = 8'hFF;
    step();
    chk("hold_w0", 32'(ack), 32'h08);
    step();
    chk("hold_w1", 32'(ack), 32'h08);
    step();
    hold = 1'b1; req = 8'h09;
    #1;
    chk("hold1_ack", 32'(ack), 0);
    chk("hold1_sel", 32'(sel), 3);
    chk("hold1_ov", 32'(out_valid), 1);
    step();
    chk("hold2_ack", 32'(ack), 0);
    chk("hold2_ov", 32'(out_valid), 0);
    chk("hold2_sel", 32'(sel), 3);
    chk("hold2_src", 32'(out_src), 3);
    chk("hold2_busy", 32'(busy), 1);
    step();
    chk("hold3_ack", 32'(ack), 0);
    chk("hold3_sel", 32'(sel), 3);
    step();
    hold = 1'b0;
    #1;
    chk("rel_w2", 32'(ack), 32'h08);
    chk("rel_w2_ov", 32'(out_valid), 0);
    step();
    chk("rel_w3", 32'(ack), 32'h08);
    chk("rel_w3_ov", 32'(out_valid), 1);
    step();
    chk("rel_next_sel", 32'(sel), 0);
    chk("rel_next_ack", 32'(ack), 32'h01);
    chk("rel_next_src", 32'(out_src), 3);

    // Request drop on ch6 after two words, ch1 waiting; then all requests drop.
    do_reset();
    req = 8'h40; mask = 8'hFF;
    step();
    chk("drop_w0", 32'(ack), 32'h40);
    step();
    chk("drop_w1", 32'(ack), 32'h40);
    step();
    req = 8'h02;
    #1;
    chk("drop_gap_ack", 32'(ack), 0);
    step();
    chk("drop_sel", 32'(sel), 1);
    chk("drop_ack1", 32'(ack), 32'h02);
    chk("drop_ov_gap", 32'(out_valid), 0);
    step();
    req = 8'h00;
    #1;
    chk("drop_all_ack", 32'(ack), 0);
    chk("drop_all_ov", 32'(out_valid), 1);
    step();
    chk("drop_all_busy", 32'(busy), 0);
    chk("drop_all_ov2", 32'(out_valid), 0);

    // Masked-off request never gets a grant.
    do_reset();
    req = 8'h01; mask = 8'hFE;
    for (int k = 0; k < 3; k++) begin
      #1;
      chk("mask_ack", 32'(ack), 0);
      step();
      chk("mask_busy", 32'(busy), 0);
    end

    // Reset under hold, mid-burst on ch4.
    mask = 8'hFF; req = 8'h10;
    step();
    chk("r4_sel", 32'(sel), 4);
    chk("r4_w0", 32'(ack), 32'h10);
    step();
    chk("r4_w1", 32'(ack), 32'h10);
    rst = 1'b1; hold = 1'b1;
    #1;
    chk("r4_rst_ack", 32'(ack), 0);
    step();
    chk("r4_sel0", 32'(sel), 0);
    chk("r4_ov0", 32'(out_valid), 0);
    chk("r4_busy0", 32'(busy), 0);
    chk("r4_src0", 32'(out_src), 0);
    rst = 1'b0; hold = 1'b0; req = '0;
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
